y_tap_line_buffer: RTL and testbench

Vertical tap generator for the bicubic Y pass. It accepts the horizontally interpolated sample stream row by row and keeps the previous three rows in internal line buffers. For every column it emits four vertically aligned 15-bit taps (8.7 fixed point), oldest row first, which drive the Y weight stage inputs tap_0..tap_3 directly. It is the producer end of that stage's four-tap interface.

---
 rtl/y_tap_line_buffer.sv | 128 ++++++++++++
 tb/tb_y_tap_line_buffer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/y_tap_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : y_tap_line_buffer
//  Description : Vertical tap generator for the bicubic Y pass. Keeps the
//                previous three rows in line buffers and emits four
//                vertically aligned taps per column, oldest row first.
//  Revision    : 1.0 - initial release
// ============================================================================
module y_tap_line_buffer #(
  parameter int LINE_W   = 64,
  parameter int COL_BITS = 6,
  parameter int DW       = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DW-1:0]       in_data,
  input  logic                in_sof,
  output logic                out_valid,
  output logic [DW-1:0]       out_tap0,
  output logic [DW-1:0]       out_tap1,
  output logic [DW-1:0]       out_tap2,
  output logic [DW-1:0]       out_tap3,
  output logic [COL_BITS-1:0] out_col,
  output logic                out_eol
);

  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(LINE_W - 1);
  localparam logic [1:0]          FILL_MAX = 2'd3;

  // Line buffers: lb0 holds row r-3, lb1 row r-2, lb2 row r-1 for each column.
  // They are deliberately left out of reset; fill gating hides stale content.
  logic [DW-1:0] lb0_q [LINE_W];
  logic [DW-1:0] lb1_q [LINE_W];
  logic [DW-1:0] lb2_q [LINE_W];

  logic [COL_BITS-1:0] col_cnt_q, col_cnt_d;
  logic [1:0]          fill_q, fill_d;
  logic                out_valid_q, out_valid_d;
  logic [DW-1:0]       tap0_q, tap0_d;
  logic [DW-1:0]       tap1_q, tap1_d;
  logic [DW-1:0]       tap2_q, tap2_d;
  logic [DW-1:0]       tap3_q, tap3_d;
  logic [COL_BITS-1:0] out_col_q, out_col_d;
  logic                out_eol_q, out_eol_d;

  logic [COL_BITS-1:0] col_eff;
  logic [1:0]          fill_eff;
  logic [DW-1:0]       rd0, rd1, rd2;

  // Next-state: column/row bookkeeping and tap capture for an accepted sample.
  always_comb begin
    col_eff     = in_sof ? '0 : col_cnt_q;
    fill_eff    = in_sof ? 2'd0 : fill_q;
    rd0         = lb0_q[col_eff];
    rd1         = lb1_q[col_eff];
    rd2         = lb2_q[col_eff];
    col_cnt_d   = col_cnt_q;
    fill_d      = fill_q;
    out_valid_d = 1'b0;
    out_eol_d   = 1'b0;
    tap0_d      = tap0_q;
    tap1_d      = tap1_q;
    tap2_d      = tap2_q;
    tap3_d      = tap3_q;
    out_col_d   = out_col_q;
    if (in_valid) begin
      tap0_d      = rd0;
      tap1_d      = rd1;
      tap2_d      = rd2;
      tap3_d      = in_data;
      out_col_d   = col_eff;
      out_valid_d = (fill_eff == FILL_MAX);
      out_eol_d   = (fill_eff == FILL_MAX) && (col_eff == LAST_COL);
      if (col_eff == LAST_COL) begin
        col_cnt_d = '0;
        fill_d    = (fill_eff == FILL_MAX) ? FILL_MAX : 2'(fill_eff + 2'd1);
      end else begin
        col_cnt_d = COL_BITS'(col_eff + 1'b1);
        fill_d    = fill_eff;
      end
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt_q   <= '0;
      fill_q      <= 2'd0;
      out_valid_q <= 1'b0;
      tap0_q      <= '0;
      tap1_q      <= '0;
      tap2_q      <= '0;
      tap3_q      <= '0;
      out_col_q   <= '0;
      out_eol_q   <= 1'b0;
    end else begin
      col_cnt_q   <= col_cnt_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      tap0_q      <= tap0_d;
      tap1_q      <= tap1_d;
      tap2_q      <= tap2_d;
      tap3_q      <= tap3_d;
      out_col_q   <= out_col_d;
      out_eol_q   <= out_eol_d;
    end
  end

  // Row shift through the line buffers at the visited column (read-before-write).
  always_ff @(posedge clk) begin
    if (!rst && in_valid) begin
      lb0_q[col_eff] <= rd1;
      lb1_q[col_eff] <= rd2;
      lb2_q[col_eff] <= in_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_tap0  = tap0_q;
  assign out_tap1  = tap1_q;
  assign out_tap2  = tap2_q;
  assign out_tap3  = tap3_q;
  assign out_col   = out_col_q;
  assign out_eol   = out_eol_q;

endmodule
`default_nettype wire

// File: tb/tb_y_tap_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_y_tap_line_buffer
//  Description : Directed self-checking bench for y_tap_line_buffer (LINE_W=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_y_tap_line_buffer;

  localparam int LW = 4;
  localparam int CB = 2;
  localparam int DW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_sof;
  logic          out_valid;
  logic [DW-1:0] out_tap0, out_tap1, out_tap2, out_tap3;
  logic [CB-1:0] out_col;
  logic          out_eol;

  int total = 0;
  int bad   = 0;
  int nvalid;

  always #5 clk = ~clk;

  y_tap_line_buffer #(.LINE_W(LW), .COL_BITS(CB), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .out_valid(out_valid), .out_tap0(out_tap0), .out_tap1(out_tap1),
    .out_tap2(out_tap2), .out_tap3(out_tap3), .out_col(out_col), .out_eol(out_eol)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Sample value for row r, column c; fs forces full-scale on column 3 of rows >= 2.
  function automatic logic [DW-1:0] val(input int base, input int r, input int c, input bit fs);
    if (fs && r >= 2 && c == 3) return 15'h7FFF;
    return DW'((base + r * 16 + c) << 7);
  endfunction

  // Apply inputs for one cycle; outputs are examined 1 time unit after the edge.
  task automatic drive(input logic v, input logic s, input logic [DW-1:0] d);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  // Stream samples start..start+n-1 of a frame (index = row*LW + col).
  task automatic run_frame(input int start, input int n, input int base,
                           input bit sof_first, input bit gap, input bit fs);
    for (int i = start; i < start + n; i++) begin
      int r = i / LW;
      int c = i % LW;
      bit ev = (r >= 3);
      drive(1'b1, sof_first && (i == 0), val(base, r, c, fs));
      chk("valid", out_valid, ev);
      chk("eol", out_eol, ev && (c == LW - 1));
      if (out_valid) nvalid++;
      if (ev) begin
        chk("tap0", out_tap0, val(base, r - 3, c, fs));
        chk("tap1", out_tap1, val(base, r - 2, c, fs));
        chk("tap2", out_tap2, val(base, r - 1, c, fs));
        chk("tap3", out_tap3, val(base, r, c, fs));
        chk("col", out_col, c);
      end
      if (gap) begin
        drive(1'b0, 1'b1, 15'h5555);
        chk("gap_valid", out_valid, 0);
        chk("gap_tap3", out_tap3, val(base, r, c, fs));
        chk("gap_col", out_col, c);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_sof = 1'b1; in_data = 15'h7FFF;

    // Reset with in_valid high for two cycles, then one idle cycle.
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; end
      @(posedge clk); #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_tap0", out_tap0, 0);
      chk("rst_tap1", out_tap1, 0);
      chk("rst_tap2", out_tap2, 0);
      chk("rst_tap3", out_tap3, 0);
      chk("rst_col", out_col, 0);
      chk("rst_eol", out_eol, 0);
    end

    // Priming: 4 rows, outputs only on row 3; spot-check the hand values.
    nvalid = 0;
    run_frame(0, 12, 0, 1, 0, 0);
    chk("prime_none", nvalid, 0);
    run_frame(12, 1, 0, 0, 0, 0);
    chk("s13_tap0", out_tap0, 15'h0000);
    chk("s13_tap1", out_tap1, 15'h0800);
    chk("s13_tap2", out_tap2, 15'h1000);
    chk("s13_tap3", out_tap3, 15'h1800);
    run_frame(13, 3, 0, 0, 0, 0);
    chk("s16_eol", out_eol, 1);
    chk("s16_tap0", out_tap0, 15'h0180);
    chk("s16_tap1", out_tap1, 15'h0980);
    chk("s16_tap2", out_tap2, 15'h1180);
    chk("s16_tap3", out_tap3, 15'h1980);
    chk("prime_cnt", nvalid, 4);

    // Same frame with an idle cycle after every sample.
    nvalid = 0;
    run_frame(0, 16, 0, 1, 1, 0);
    chk("gap_cnt", nvalid, 4);

    // Steady state over 6 rows; row 5 col 2 carries rows 2..5 of column 2.
    nvalid = 0;
    run_frame(0, 23, 0, 1, 0, 0);
    chk("r5c2_tap0", out_tap0, 15'h1100);
    chk("r5c2_tap1", out_tap1, 15'h1900);
    chk("r5c2_tap2", out_tap2, 15'h2100);
    chk("r5c2_tap3", out_tap3, 15'h2900);
    run_frame(23, 1, 0, 0, 0, 0);
    chk("steady_cnt", nvalid, 12);

    // in_sof mid-row at row 4 col 1: new frame primes again from scratch.
    run_frame(0, 17, 0, 1, 0, 0);
    nvalid = 0;
    run_frame(0, 12, 8'h40, 1, 0, 0);
    chk("sof_none", nvalid, 0);
    run_frame(12, 4, 8'h40, 0, 0, 0);
    chk("sof_cnt", nvalid, 4);

    // Reset at row 3 col 2, then resume without in_sof; full-scale data passes.
    run_frame(0, 14, 8'h20, 1, 0, 0);
    rst = 1'b1;
    drive(1'b1, 1'b0, 15'h1234);
    rst = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_tap3", out_tap3, 0);
    chk("mid_rst_col", out_col, 0);
    nvalid = 0;
    run_frame(0, 12, 8'h30, 0, 0, 1);
    chk("rst_none", nvalid, 0);
    run_frame(12, 4, 8'h30, 0, 0, 1);
    chk("fs_tap2", out_tap2, 15'h7FFF);
    chk("fs_tap3", out_tap3, 15'h7FFF);
    chk("rst_cnt", nvalid, 4);

    drive(1'b0, 1'b0, '0);
    chk("idle_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
